// File: rtl/bus_decoder.sv
// -----------------------------------------------------------------------------
// bus_decoder
//
// Purpose:
//   Single-master, NSLAVES-slave bus decoder. Each master request is
//   registered, routed to the lowest-indexed slave whose bank ID matches the
//   top BANK_W address bits, and terminated back to the master with a
//   one-cycle ack. Read data is masked per byte lane. Unmapped banks terminate
//   with an error ack. With BUS_DECODER_TIMEOUT_EN defined, a slave that does
//   not ack within TIMEOUT BUSY cycles also terminates with an error ack.
//
// Configuration macro:
//   BUS_DECODER_TIMEOUT_EN - compile in the BUSY timeout counter and error path.
//                            Undefined: BUSY waits for the slave ack forever.
//
// Handshake:
//   The master raises m_stb_i and holds it, with m_adr_i/m_dat_i/m_sel_i/m_we_i
//   stable, until m_ack_o; m_ack_o is a single-cycle pulse and m_err_o/m_dat_o
//   are valid only while it is high. Towards the slaves, s_stb_o[k] is held
//   until s_ack_i[k] is seen; s_dat_i slice k must be valid in that ack cycle.
//
// Ports:
//   clk, rst_i                 clock, asynchronous active-high reset
//   m_adr_i/m_dat_i/m_sel_i    master address, write data, byte lane selects
//   m_we_i/m_stb_i             master write enable, request strobe
//   m_ack_o/m_err_o/m_dat_o    master termination pulse, error flag, read data
//   s_stb_o                    one-hot slave strobes
//   s_adr_o/s_dat_o/s_sel_o    address/write data/lane selects to all slaves
//   s_we_o                     write enable to all slaves
//   s_ack_i/s_dat_i            slave acks and packed slave read data
//   err_adr_o/err_cnt_o        last errored address, saturating error count
//
// Debug: FSM state is held in state_q (state_e: ST_IDLE, ST_BUSY, ST_DONE).
// -----------------------------------------------------------------------------
module bus_decoder #(
  parameter int                        NSLAVES  = 4,
  parameter int                        ADDR_W   = 32,
  parameter int                        DATA_W   = 32,
  parameter int                        BANK_W   = 8,
  parameter logic [NSLAVES*BANK_W-1:0] BANK_IDS = {8'h03, 8'h02, 8'h01, 8'h00},
  parameter int                        TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        rst_i,
  input  logic [ADDR_W-1:0]           m_adr_i,
  input  logic [DATA_W-1:0]           m_dat_i,
  input  logic [DATA_W/8-1:0]         m_sel_i,
  input  logic                        m_we_i,
  input  logic                        m_stb_i,
  output logic                        m_ack_o,
  output logic                        m_err_o,
  output logic [DATA_W-1:0]           m_dat_o,
  output logic [NSLAVES-1:0]          s_stb_o,
  output logic [ADDR_W-1:0]           s_adr_o,
  output logic [DATA_W-1:0]           s_dat_o,
  output logic [DATA_W/8-1:0]         s_sel_o,
  output logic                        s_we_o,
  input  logic [NSLAVES-1:0]          s_ack_i,
  input  logic [NSLAVES*DATA_W-1:0]   s_dat_i,
  output logic [ADDR_W-1:0]           err_adr_o,
  output logic [7:0]                  err_cnt_o
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [NSLAVES-1:0]  s_stb_q;
  logic [ADDR_W-1:0]   s_adr_q;
  logic [DATA_W-1:0]   s_dat_q;
  logic [SEL_W-1:0]    s_sel_q;
  logic                s_we_q;
  logic                m_ack_q;
  logic                m_err_q;
  logic [DATA_W-1:0]   m_dat_q;
  logic [ADDR_W-1:0]   err_adr_q;
  logic [7:0]          err_cnt_q;

  // Bank decode: first match scanning upward, so duplicate IDs resolve to the
  // lowest slave index.
  logic [BANK_W-1:0]   bank;
  logic [NSLAVES-1:0]  hit_oh;
  logic                found;

  assign bank = m_adr_i[ADDR_W-1 -: BANK_W];

  always_comb begin
    hit_oh = '0;
    found  = 1'b0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (!found && (bank == BANK_IDS[k*BANK_W +: BANK_W])) begin
        hit_oh[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Read path: s_stb_q is one-hot, so OR-ing the gated slices selects the
  // active slave without an index decode.
  logic [DATA_W-1:0] rd_sel;
  logic [DATA_W-1:0] rd_masked;
  logic              ack_hit;

  always_comb begin
    rd_sel    = '0;
    rd_masked = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (s_stb_q[k]) begin
        rd_sel = rd_sel | s_dat_i[k*DATA_W +: DATA_W];
      end
    end
    for (int b = 0; b < SEL_W; b++) begin
      rd_masked[b*8 +: 8] = s_sel_q[b] ? rd_sel[b*8 +: 8] : 8'h00;
    end
  end

  // Acks from slaves that are not currently strobed are ignored.
  assign ack_hit = |(s_ack_i & s_stb_q);

  logic tmo_hit;

`ifdef BUS_DECODER_TIMEOUT_EN
  // tmo_cnt_q counts completed BUSY cycles, so in the TIMEOUT-th BUSY cycle it
  // holds TIMEOUT-1 and the FSM leaves BUSY at the following edge.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_BUSY) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`else
  // TIMEOUT has no effect in this build; BUSY waits for the ack.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      s_stb_q   <= '0;
      s_adr_q   <= '0;
      s_dat_q   <= '0;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      m_ack_q   <= 1'b0;
      m_err_q   <= 1'b0;
      m_dat_q   <= '0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      // Termination outputs are single-cycle; they are only set on DONE entry.
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
      m_dat_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (m_stb_i) begin
            s_adr_q <= m_adr_i;
            s_dat_q <= m_dat_i;
            s_sel_q <= m_sel_i;
            s_we_q  <= m_we_i;
            if (found) begin
              s_stb_q <= hit_oh;
              state_q <= ST_BUSY;
            end else begin
              m_ack_q   <= 1'b1;
              m_err_q   <= 1'b1;
              err_adr_q <= m_adr_i;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              state_q   <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          // An ack in the same cycle as the timeout takes priority.
          if (ack_hit) begin
            s_stb_q <= '0;
            m_ack_q <= 1'b1;
            m_dat_q <= s_we_q ? '0 : rd_masked;
            state_q <= ST_DONE;
          end else if (tmo_hit) begin
            s_stb_q   <= '0;
            m_ack_q   <= 1'b1;
            m_err_q   <= 1'b1;
            err_adr_q <= s_adr_q;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_ack_o   = m_ack_q;
  assign m_err_o   = m_err_q;
  assign m_dat_o   = m_dat_q;
  assign s_stb_o   = s_stb_q;
  assign s_adr_o   = s_adr_q;
  assign s_dat_o   = s_dat_q;
  assign s_sel_o   = s_sel_q;
  assign s_we_o    = s_we_q;
  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_bus_decoder.sv
// -----------------------------------------------------------------------------
// tb_bus_decoder
//
// Directed bench for bus_decoder (4 slaves, default bank IDs 00..03,
// TIMEOUT=6). A transaction-level model predicts, per request, the ack cycle,
// error flag, read data and the error bookkeeping; one compare process checks
// every m_ack_o against that queue. Literal checks pin the model on the
// documented scenarios. Timeout scenarios run only when BUS_DECODER_TIMEOUT_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_bus_decoder;

  localparam int NS    = 4;
  localparam int TMO   = 6;
  localparam int NEVER = 100000;
`ifdef BUS_DECODER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- DUT ----------------
  logic [31:0]      m_adr_i = '0;
  logic [31:0]      m_dat_i = '0;
  logic [3:0]       m_sel_i = '0;
  logic             m_we_i  = 1'b0;
  logic             m_stb_i = 1'b0;
  logic             m_ack_o;
  logic             m_err_o;
  logic [31:0]      m_dat_o;
  logic [NS-1:0]    s_stb_o;
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic [NS-1:0]    s_ack_i = '0;
  logic [NS*32-1:0] s_dat_i = '0;
  logic [31:0]      err_adr_o;
  logic [7:0]       err_cnt_o;

  bus_decoder #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_we_i    (m_we_i),
    .m_stb_i   (m_stb_i),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_dat_o   (m_dat_o),
    .s_stb_o   (s_stb_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_we_o    (s_we_o),
    .s_ack_i   (s_ack_i),
    .s_dat_i   (s_dat_i),
    .err_adr_o (err_adr_o),
    .err_cnt_o (err_cnt_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- slave configuration / responder ----------------
  logic [7:0]  bank_tab [NS] = '{8'h00, 8'h01, 8'h02, 8'h03};
  int          slv_delay[NS] = '{0, 0, 0, 0};
  logic [31:0] slv_data [NS] = '{32'h0, 32'h0, 32'h0, 32'h0};
  int          stb_seen [NS] = '{0, 0, 0, 0};
  logic [NS-1:0] noise_ack = '0;

  // Slave k acks slv_delay[k] cycles after its strobe rises; read data is only
  // valid in the ack cycle, garbage otherwise.
  initial begin : responder
    int busy_cnt[NS];
    logic [NS-1:0] ack_v;
    for (int k = 0; k < NS; k++) busy_cnt[k] = 0;
    forever begin
      @(negedge clk);
      ack_v = '0;
      for (int k = 0; k < NS; k++) begin
        s_dat_i[k*32 +: 32] = 32'hDEAD0000 | 32'(k);
        if (s_stb_o[k]) begin
          stb_seen[k]++;
          if (busy_cnt[k] == slv_delay[k]) begin
            ack_v[k]            = 1'b1;
            s_dat_i[k*32 +: 32] = slv_data[k];
          end
          busy_cnt[k]++;
        end else begin
          busy_cnt[k] = 0;
        end
      end
      s_ack_i = ack_v | noise_ack;
    end
  end

  // ---------------- model + scoreboard ----------------
  // exp_q entry: {ack_cycle[31:0], err, dat[31:0], err_adr[31:0], err_cnt[7:0]}
  logic [104:0] exp_q[$];
  logic [31:0]  mdl_err_adr = '0;
  int           mdl_err_cnt = 0;

  function automatic logic [104:0] model(input logic [31:0] adr, input logic we,
                                         input logic [3:0] sel, input int req_cyc);
    int k;
    int lat;
    logic err;
    logic [31:0] d;
    k = -1;
    for (int i = NS - 1; i >= 0; i--) if (bank_tab[i] == adr[31:24]) k = i;
    d = 32'h0;
    if (k < 0) begin
      lat = 1;
      err = 1'b1;
    end else if (TMO_EN && slv_delay[k] >= TMO) begin
      lat = TMO + 1;
      err = 1'b1;
    end else begin
      lat = 2 + slv_delay[k];
      err = 1'b0;
      if (!we) begin
        for (int b = 0; b < 4; b++) if (sel[b]) d = d + (slv_data[k] & (32'hFF << (8 * b)));
      end
    end
    if (err) begin
      mdl_err_adr = adr;
      if (mdl_err_cnt < 255) mdl_err_cnt++;
    end
    return {32'(req_cyc + lat), err, d, mdl_err_adr, 8'(mdl_err_cnt)};
  endfunction

  initial begin : compare
    logic [104:0] e;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        check("stb_onehot", 32'($countones(s_stb_o) <= 1), 32'd1);
        if (m_ack_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'(m_ack_o), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack_cycle", 32'(cyc), e[104:73]);
            check("ack_err",   32'(m_err_o), 32'(e[72]));
            check("ack_dat",   m_dat_o, e[71:40]);
            check("err_adr",   err_adr_o, e[39:8]);
            check("err_cnt",   32'(err_cnt_o), 32'(e[7:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, output int lat, output logic err, output logic [31:0] rdat);
    int req_cyc;
    int waited;
    @(negedge clk);
    m_adr_i = adr;
    m_dat_i = dat;
    m_sel_i = sel;
    m_we_i  = we;
    m_stb_i = 1'b1;
    req_cyc = cyc;
    exp_q.push_back(model(adr, we, sel, req_cyc));
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!m_ack_o && waited < 2000);
    check("ack_seen", 32'(m_ack_o), 32'd1);
    lat     = cyc - req_cyc;
    err     = m_err_o;
    rdat    = m_dat_o;
    m_stb_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_ack"},   32'(m_ack_o), 32'd0);
    check({tag, "_m_err"},   32'(m_err_o), 32'd0);
    check({tag, "_m_dat"},   m_dat_o, 32'd0);
    check({tag, "_s_stb"},   32'(s_stb_o), 32'd0);
    check({tag, "_s_adr"},   s_adr_o, 32'd0);
    check({tag, "_s_dat"},   s_dat_o, 32'd0);
    check({tag, "_s_sel"},   32'(s_sel_o), 32'd0);
    check({tag, "_s_we"},    32'(s_we_o), 32'd0);
    check({tag, "_err_adr"}, err_adr_o, 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt_o), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          seen0[NS];
    int          waited;

    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_i = 1'b0;
    @(negedge clk);
    check_zero("post_rst");

    // Mapped read, slave 0 acks immediately, lanes 0 and 2 selected.
    slv_data[0]  = 32'h11223344;
    slv_delay[0] = 0;
    do_txn(32'h0000_0010, 32'h0, 4'b0101, 1'b0, lat, err, rd);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_dat", rd, 32'h00220044);
    check("rd_err", 32'(err), 32'd0);

    // Mapped write to slave 1; returned data must be zero.
    slv_data[1]  = 32'hFFFF_FFFF;
    slv_delay[1] = 0;
    seen0 = stb_seen;
    do_txn(32'h0100_0000, 32'h0000_00A5, 4'b0001, 1'b1, lat, err, rd);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_stb1_cycles", 32'(stb_seen[1] - seen0[1]), 32'd1);
    check("wr_stb_other", 32'((stb_seen[0] - seen0[0]) + (stb_seen[2] - seen0[2]) + (stb_seen[3] - seen0[3])), 32'd0);
    check("wr_s_dat", s_dat_o, 32'h0000_00A5);
    check("wr_s_adr", s_adr_o, 32'h0100_0000);
    check("wr_s_sel", 32'(s_sel_o), 32'd1);
    check("wr_s_we",  32'(s_we_o), 32'd1);
    check("wr_m_dat", rd, 32'd0);
    check("wr_err",   32'(err), 32'd0);

    // Unmapped bank 0x7F.
    seen0 = stb_seen;
    do_txn(32'h7F00_0010, 32'h0, 4'hF, 1'b0, lat, err, rd);
    check("um_lat", 32'(lat), 32'd1);
    check("um_err", 32'(err), 32'd1);
    check("um_dat", rd, 32'd0);
    check("um_no_stb", 32'((stb_seen[0] - seen0[0]) + (stb_seen[1] - seen0[1]) + (stb_seen[2] - seen0[2]) + (stb_seen[3] - seen0[3])), 32'd0);
    @(negedge clk);
    check("um_err_adr", err_adr_o, 32'h7F00_0010);
    check("um_err_cnt", 32'(err_cnt_o), 32'd1);

    // Wait states: slave 3 acks 5 cycles after its strobe (TIMEOUT-1).
    slv_data[3]  = 32'hCAFE_F00D;
    slv_delay[3] = 5;
    do_txn(32'h0300_0100, 32'h0, 4'hF, 1'b0, lat, err, rd);
    check("ws_lat", 32'(lat), 32'd7);
    check("ws_err", 32'(err), 32'd0);
    check("ws_dat", rd, 32'hCAFE_F00D);

    // Acks from non-selected slaves are ignored.
    slv_data[2]  = 32'h89AB_CDEF;
    slv_delay[2] = 2;
    noise_ack    = 4'b1011;
    do_txn(32'h0200_0020, 32'h0, 4'b1010, 1'b0, lat, err, rd);
    noise_ack    = 4'b0000;
    check("noise_lat", 32'(lat), 32'd4);
    check("noise_dat", rd, 32'h8900_CD00);

`ifdef BUS_DECODER_TIMEOUT_EN
    // Slave 2 never acks: strobe held TIMEOUT cycles, then error ack.
    slv_delay[2] = NEVER;
    seen0 = stb_seen;
    do_txn(32'h0200_0040, 32'h0, 4'hF, 1'b0, lat, err, rd);
    check("tmo_lat", 32'(lat), 32'd7);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_dat", rd, 32'd0);
    check("tmo_stb_cycles", 32'(stb_seen[2] - seen0[2]), 32'd6);
    @(negedge clk);
    check("tmo_err_adr", err_adr_o, 32'h0200_0040);
    check("tmo_err_cnt", 32'(err_cnt_o), 32'd2);
    for (int i = 0; i < 3; i++) do_txn(32'h0200_0044 + 32'(i * 4), 32'h0, 4'hF, 1'b0, lat, err, rd);
    slv_delay[2] = 2;
`endif

    // Error counter saturation via repeated unmapped reads.
    for (int i = 0; i < 300; i++) do_txn(32'h8000_0000 + 32'(i * 4), 32'h0, 4'hF, 1'b0, lat, err, rd);
    @(negedge clk);
    check("sat_err_cnt", 32'(err_cnt_o), 32'd255);
    check("sat_err_adr", err_adr_o, 32'h8000_04AC);

    // Reset in the middle of BUSY: everything clears, no ack is produced.
    slv_delay[1] = NEVER;
    @(negedge clk);
    m_adr_i = 32'h0100_0080;
    m_we_i  = 1'b0;
    m_sel_i = 4'hF;
    m_stb_i = 1'b1;
    waited  = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!s_stb_o[1] && waited < 20);
    check("rb_busy", 32'(s_stb_o[1]), 32'd1);
    @(negedge clk);
    #2;
    rst_i   = 1'b1;
    m_stb_i = 1'b0;
    #1;
    check_zero("rb");
    repeat (2) begin
      @(negedge clk);
      check("rb_no_ack", 32'(m_ack_o), 32'd0);
    end
    mdl_err_adr = '0;
    mdl_err_cnt = 0;
    rst_i = 1'b0;

    // First request after reset completes normally.
    slv_delay[1] = 0;
    slv_data[1]  = 32'h5A5A_5A5A;
    do_txn(32'h0100_0004, 32'h0, 4'b1100, 1'b0, lat, err, rd);
    check("ar_lat", 32'(lat), 32'd2);
    check("ar_dat", rd, 32'h5A5A_0000);
    check("ar_err", 32'(err), 32'd0);
    check("ar_err_cnt", 32'(err_cnt_o), 32'd0);

    @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
